dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory (`Memory`). It shares the memory between the CPU load/store path (port 0) and the debug/DMA loader (port 1), and issues at most one access at a time. It drives `MemRead_signal` and `MemWrite_signal`, and captures the registered `readData`. It sits between the MEM pipeline stage and `Memory`, and adds a range check against memory depth.

## Interface
- `DEPTH`, 301: number of 32-bit words in data memory; valid addresses are 0..DEPTH-1
- `AW`, 32: address width
- `DW`, 32: data width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req0`/`req1` in 1: access request; hold high until `gnt` is seen
- `we0`/`we1` in 1: 1 = write, 0 = read; stable while `req` is high
- `addr0`/`addr1` in AW: word address; stable while `req` is high
- `wdata0`/`wdata1` in DW: write data; stable while `req` is high
- `gnt0`/`gnt1` out 1: one-cycle pulse; the request was accepted
- `done0`/`done1` out 1: one-cycle pulse; the access completed
- `err0`/`err1` out 1: valid with `done`; 1 = address out of range
- `rdata0`/`rdata1` out DW: read data; valid with `done` on a read; holds its value otherwise
- `mem_addr` out AW: to `Memory.address`
- `mem_wdata` out DW: to `Memory.writeData`
- `mem_read` out 1: to `MemRead_signal`
- `mem_write` out 1: to `MemWrite_signal`
- `mem_rdata` in DW: from `Memory.readData`

## Operation
- FSM has three states, cycled in order:
  - IDLE: arbitrate when any `req` is high; otherwise stay in IDLE.
  - ISSUE: always one cycle, then RESP.
  - RESP: always one cycle, then IDLE.
- Arbitration is sampled only in IDLE:
  - Round-robin with a 1-bit `last` pointer.
  - If both requests are high, grant the port that is not `last`.
  - A single request wins regardless of `last`.
  - `last` updates to the granted port.
- On leaving IDLE:
  - Latch the winner's id, `we`, `addr` and `wdata`.
  - Register `gnt<id>`=1 for the ISSUE cycle.
  - Compute `oor` = (addr >= DEPTH) using a full AW-bit compare.
- In ISSUE:
  - `mem_addr` and `mem_wdata` carry the latched values.
  - If `oor`=0: `mem_read` = !we and `mem_write` = we.
  - If `oor`=1: both strobes stay 0; no memory access occurs.
- In RESP:
  - If the access was an in-range read, `mem_rdata` is valid and is captured into `rdata<id>`.
  - Otherwise `rdata<id>` is unchanged, except an out-of-range read, which loads 0.
- On leaving RESP:
  - `done<id>`=1 for one cycle.
  - `err<id>` = `oor` for that same cycle; `err<id>` is 0 whenever `done<id>` is 0.
- A requester must drop `req` in the cycle after `gnt`, or keep it high to request again. A `req` still high when IDLE is re-entered counts as a new request.
- Strobes are never both high. `mem_addr`, `mem_wdata` and the strobes are 0 outside ISSUE.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, `last`=1 (port 0 wins the first tie).
- Read latency with the request sampled at edge E:
  - `gnt` and the strobes are high in cycle E..E+1.
  - `Memory` samples at E+1.
  - `mem_rdata` is valid in RESP.
  - `done` and `rdata` are high/valid in cycle E+2..E+3.
- Writes and out-of-range accesses have identical latency; `done` always follows `gnt` by exactly 2 cycles.
- Throughput: one access per 3 cycles. The `done` cycle coincides with IDLE, so the next `gnt` can follow at the next edge.
- Reset mid-access:
  - All outputs clear immediately (asynchronous).
  - Assertion during ISSUE deasserts `mem_write` before the edge, so the write is suppressed.
  - No `done` is issued; the requester must re-request.
- `req` changes while not in IDLE are ignored.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, RESP);
  - port id constants PORT_CPU=0 and PORT_DBG=1;
  - default width constants.
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs: `req[1:0]` and `last`. Outputs: `grant_valid` and `grant_id`.
- The remaining logic is one FSM plus latches in `dmem_arbiter`.

## Test plan
- Single read: memory word 5 holds 0xDEADBEEF; `req0` high with `we0`=0 and `addr0`=5, from IDLE after reset. Required: `gnt0` at the next edge, `mem_read`=1 for one cycle, then `done0`=1, `rdata0`=0xDEADBEEF, `err0`=0, `done0` exactly 2 cycles after `gnt0`.
- Write then read: port 1 writes 0x12345678 to address 10, then reads address 10. Required: `mem_write` is high for exactly one cycle, and the read returns 0x12345678 on `rdata1`.
- Contention:
  - `req0` and `req1` both held high for 4 accesses after reset.
  - Required grant order: 0, 1, 0, 1.
  - Required: no cycle with both `gnt` pulses high, and no cycle with both strobes high.
- Out of range: `addr0`=301 read, then `addr0`=0xFFFFFFFF write. Required for both: strobes stay 0, `done0` with `err0`=1, `rdata0`=0 after the read, memory unchanged.
- Reset during ISSUE of a write of 0xAAAA to address 3: pull `rst_n` low mid-cycle. Required: all outputs go to 0 immediately, word 3 keeps its old value, no `done`, and the first grant after reset honors port 0 on a tie.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned DEF_DEPTH = 301;
  localparam int unsigned DEF_AW    = 32;
  localparam int unsigned DEF_DW    = 32;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  // On a tie the port that did not win last time is picked; a lone request always wins.
  always_comb begin
    grant_valid = |req;
    grant_id    = PORT_CPU;
    if (req == 2'b11) grant_id = ~last;
    else if (req[1])  grant_id = PORT_DBG;
  end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port data memory.
// IDLE -> ISSUE -> RESP -> IDLE; one access per three cycles, all outputs registered.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          grant_valid, grant_id;
  logic          sel_we, sel_oor;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] rd_val;

  rr_arb2 u_rr_arb2 (
    .req         ({req1, req0}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Winner's request fields and its full-width range check.
  always_comb begin
    sel_we    = (grant_id == PORT_DBG) ? we1    : we0;
    sel_addr  = (grant_id == PORT_DBG) ? addr1  : addr0;
    sel_wdata = (grant_id == PORT_DBG) ? wdata1 : wdata0;
    sel_oor   = (sel_addr >= AW'(DEPTH));
  end

  // Next-state and next-output logic. The latched address and write data
  // live directly in mem_addr_q/mem_wdata_q, which are only nonzero in ISSUE.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    we_d        = we_q;
    oor_d       = oor_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rd_val      = oor_q ? '0 : mem_rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d     = ST_ISSUE;
          last_d      = grant_id;
          id_d        = grant_id;
          we_d        = sel_we;
          oor_d       = sel_oor;
          gnt0_d      = (grant_id == PORT_CPU);
          gnt1_d      = (grant_id == PORT_DBG);
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_read_d  = !sel_we && !sel_oor;
          mem_write_d = sel_we && !sel_oor;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (id_q == PORT_DBG) begin
          done1_d = 1'b1;
          err1_d  = oor_q;
          if (!we_q) rdata1_d = rd_val;
        end else begin
          done0_d = 1'b1;
          err0_d  = oor_q;
          if (!we_q) rdata0_d = rd_val;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_DBG;
      id_q        <= PORT_CPU;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule : dmem_arbiter
